core_csr_seq: RTL and testbench
===============================

CORE_CSR_SEQ -- requirements
Module: core_csr_seq

Interface
REQ-001 SHALL have parameter ERR_CNT_W, default 8, width of the saturating CSR error counter.
REQ-002 SHALL have port g_clk  input  1  the only clock; all state updates on its rising edge.
REQ-003 SHALL have port g_reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-006 SHALL have port cmd_op  input  2  operation: 00 read, 01 write, 10 set, 11 clear.
REQ-007 SHALL have port cmd_addr  input  12  CSR address.
REQ-008 SHALL have port cmd_wdata  input  64  write, set or clear data.
REQ-009 SHALL have port rsp_valid  output  1  response available.
REQ-010 SHALL have port rsp_ready  input  1  response consumed when high together with rsp_valid.
REQ-011 SHALL have port rsp_rdata  output  64  returned CSR data.
REQ-012 SHALL have port rsp_error  output  1  CSR access error.
REQ-013 SHALL have the CSR initiator ports csr_en, csr_wr, csr_wr_set, csr_wr_clr (each output 1), csr_addr (output 12) and csr_wdata (output 64).
REQ-014 SHALL have the CSR return ports csr_rdata (input 64) and csr_error (input 1); the responder returns both combinationally in the same cycle as csr_en.
REQ-015 SHALL have ports busy (output 1), err_clr (input 1) and err_cnt (output ERR_CNT_W).

Function
REQ-016 SHALL implement the FSM states IDLE, ISSUE, READBACK and RESP.
REQ-017 SHALL drive cmd_ready high only in IDLE; on a cmd_valid and cmd_ready handshake it SHALL register op, addr and wdata and move to ISSUE.
REQ-018 In ISSUE, SHALL assert csr_en for exactly one cycle and drive csr_addr and csr_wdata from the registered command.
REQ-019 In ISSUE, SHALL set csr_wr=1 for ops 01, 10 and 11, csr_wr_set=1 only for op 10, and csr_wr_clr=1 only for op 11; all three SHALL be 0 for a read.
REQ-020 SHALL sample csr_rdata and csr_error at the end of each cycle in which csr_en=1.
REQ-021 SHALL hold rsp_valid high in RESP, with rsp_rdata and rsp_error stable, until rsp_ready is seen; it SHALL then return to IDLE.
REQ-022 Minimum command-accept to rsp_valid latency SHALL be 2 cycles without readback and 3 cycles with readback; peak throughput SHALL be one command per 3 cycles (4 with readback).
REQ-023 Outside ISSUE and READBACK, all csr_* outputs SHALL be 0.
REQ-024 busy SHALL be high in every state except IDLE.
REQ-025 err_cnt SHALL increment by 1 for each CSR cycle with csr_error=1 and SHALL saturate at all-ones.
REQ-026 err_clr SHALL zero err_cnt; if err_clr coincides with an increment, the clear SHALL win and the result SHALL be 0.
REQ-027 A cmd_valid that is held while the FSM is not in IDLE SHALL be neither accepted nor dropped; it SHALL stay pending until the next IDLE cycle.

Reset
REQ-028 While g_reset=1, SHALL set state=IDLE, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, err_cnt=0, busy=0, and all csr_* outputs to 0.
REQ-029 A reset asserted mid-operation, in any of ISSUE, READBACK or RESP, SHALL abandon the transaction without emitting a response; cmd_ready SHALL be 1 on the first cycle after g_reset deasserts.

Configuration
REQ-030 The macro CORE_CSR_SEQ_READBACK_EN SHALL control the readback feature.
REQ-031 When CORE_CSR_SEQ_READBACK_EN is defined, a write, set or clear SHALL go from ISSUE to READBACK, which issues one read (csr_en=1, csr_wr=0) to the same address.
REQ-032 With readback, rsp_rdata SHALL be the readback value and rsp_error SHALL be the OR of the errors from both CSR cycles; a read SHALL skip READBACK.
REQ-033 When the macro is undefined, the READBACK state SHALL be absent, and a write, set or clear SHALL return the csr_rdata sampled during the ISSUE cycle (the pre-write value).

Verification
REQ-034 Read 0x3AE with the responder returning 0x1234 and error 0 -> exactly one csr_en pulse with csr_wr=0; rsp_valid appears 2 cycles after accept with rsp_rdata=0x1234 and rsp_error=0.
REQ-035 Set to 0x3A0 with wdata=0x0F while the register holds 0xF0 -> csr_wr=1 and csr_wr_set=1 for one cycle; with readback, rsp_rdata=0xFF after 3 cycles; without readback, rsp_rdata=0xF0 after 2 cycles.
REQ-036 Response backpressure (rsp_ready=0 for 5 cycles) with a second command pending -> rsp_valid and rsp_rdata stay stable, cmd_ready=0, and no second csr_en appears until after the rsp handshake.
REQ-037 With ERR_CNT_W=2, run 5 commands each returning csr_error=1 -> err_cnt sequences 1, 2, 3, 3, 3; err_clr on the same cycle as the 6th error -> err_cnt=0.
REQ-038 Assert g_reset during ISSUE of a write -> no rsp_valid is produced, csr_en=0 the cycle after reset, and cmd_ready=1 on the first post-reset cycle.

Source files
------------

// File: rtl/core_csr_seq_if.sv
// core_csr_seq_if: command, response and CSR initiator bus of the CSR sequencer
interface core_csr_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [11:0] cmd_addr;
    logic [63:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_error;
    logic        csr_en;
    logic        csr_wr;
    logic        csr_wr_set;
    logic        csr_wr_clr;
    logic [11:0] csr_addr;
    logic [63:0] csr_wdata;
    logic [63:0] csr_rdata;
    logic        csr_error;

    // the sequencer: serves commands, initiates CSR cycles
    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, csr_rdata, csr_error,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
        output csr_en, csr_wr, csr_wr_set, csr_wr_clr, csr_addr, csr_wdata
    );

    // the environment: issues commands and answers CSR cycles
    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, csr_rdata, csr_error,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
        input  csr_en, csr_wr, csr_wr_set, csr_wr_clr, csr_addr, csr_wdata
    );
endinterface

// File: rtl/core_csr_seq.sv
// core_csr_seq: command-to-CSR sequencer; define CORE_CSR_SEQ_READBACK_EN to read back after writes
module core_csr_seq #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 g_clk,
    input  logic                 g_reset,
    core_csr_seq_if.slave        bus,
    output logic                 busy,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_SET = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

`ifdef CORE_CSR_SEQ_READBACK_EN
    typedef enum logic [1:0] {IDLE, ISSUE, READBACK, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
`endif

    state_t                 state, state_d;
    logic [1:0]             op_q;
    logic [11:0]            addr_q;
    logic [63:0]            wdata_q;
    logic [63:0]            rdata_q;
    logic                   err_q;
    logic [ERR_CNT_W-1:0]   cnt_q;
    logic                   cmd_ready, rsp_valid, csr_en, csr_wr, csr_wr_set, csr_wr_clr;
    logic [11:0]            csr_addr;
    logic [63:0]            csr_wdata;

    // state register; reset abandons any in-flight transaction
    always_ff @(posedge g_clk) begin
        if (g_reset) state <= IDLE;
        else         state <= state_d;
    end

    // next state and all handshake/CSR outputs; reset forces every output low at once
    always_comb begin
        state_d    = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b0;
        csr_en     = 1'b0;
        csr_wr     = 1'b0;
        csr_wr_set = 1'b0;
        csr_wr_clr = 1'b0;
        csr_addr   = '0;
        csr_wdata  = '0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) state_d = ISSUE;
            end
            ISSUE: begin
                busy       = 1'b1;
                csr_en     = 1'b1;
                csr_wr     = op_q != OP_RD;
                csr_wr_set = op_q == OP_SET;
                csr_wr_clr = op_q == OP_CLR;
                csr_addr   = addr_q;
                csr_wdata  = wdata_q;
`ifdef CORE_CSR_SEQ_READBACK_EN
                state_d    = op_q == OP_RD ? RESP : READBACK;
`else
                state_d    = RESP;
`endif
            end
`ifdef CORE_CSR_SEQ_READBACK_EN
            READBACK: begin
                busy     = 1'b1;
                csr_en   = 1'b1;
                csr_addr = addr_q;
                state_d  = RESP;
            end
`endif
            RESP: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (g_reset) begin
            cmd_ready  = 1'b0;
            rsp_valid  = 1'b0;
            busy       = 1'b0;
            csr_en     = 1'b0;
            csr_wr     = 1'b0;
            csr_wr_set = 1'b0;
            csr_wr_clr = 1'b0;
            csr_addr   = '0;
            csr_wdata  = '0;
        end
    end

    // command capture and CSR return sampling; readback overwrites data and accumulates error
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (cmd_ready && bus.cmd_valid) begin
                op_q    <= bus.cmd_op;
                addr_q  <= bus.cmd_addr;
                wdata_q <= bus.cmd_wdata;
            end
            if (state == ISSUE) begin
                rdata_q <= bus.csr_rdata;
                err_q   <= bus.csr_error;
            end
`ifdef CORE_CSR_SEQ_READBACK_EN
            if (state == READBACK) begin
                rdata_q <= bus.csr_rdata;
                err_q   <= err_q | bus.csr_error;
            end
`endif
        end
    end

    // saturating error counter; clear wins over a coincident increment
    always_ff @(posedge g_clk) begin
        if (g_reset || err_clr)                       cnt_q <= '0;
        else if (csr_en && bus.csr_error && ~&cnt_q)  cnt_q <= cnt_q + ERR_CNT_W'(1);
    end

    assign bus.cmd_ready  = cmd_ready;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_rdata  = g_reset ? '0 : rdata_q;
    assign bus.rsp_error  = !g_reset && err_q;
    assign bus.csr_en     = csr_en;
    assign bus.csr_wr     = csr_wr;
    assign bus.csr_wr_set = csr_wr_set;
    assign bus.csr_wr_clr = csr_wr_clr;
    assign bus.csr_addr   = csr_addr;
    assign bus.csr_wdata  = csr_wdata;
    assign err_cnt        = g_reset ? '0 : cnt_q;
endmodule

// File: tb/tb_core_csr_seq.sv
// tb_core_csr_seq: directed self-checking bench for core_csr_seq, with a one-register CSR responder
module tb_core_csr_seq;
`ifdef CORE_CSR_SEQ_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        err_clr = 1'b0;
    logic        err_inj = 1'b0;
    logic        busy;
    logic [1:0]  err_cnt;
    logic [63:0] mem_val = '0;
    logic        pend = 1'b0, pend_set = 1'b0, pend_clr = 1'b0;
    logic [63:0] pend_wd = '0;
    logic [11:0] last_addr = '0;
    int          en_cnt = 0, set_cnt = 0, wr_cnt = 0;
    int          tests = 0, fails = 0;

    core_csr_seq_if ifc ();

    core_csr_seq #(.ERR_CNT_W(2)) dut (
        .g_clk   (clk),
        .g_reset (rst),
        .bus     (ifc),
        .busy    (busy),
        .err_clr (err_clr),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    assign ifc.csr_rdata = mem_val;
    assign ifc.csr_error = err_inj;

    // observe CSR cycles mid-cycle and queue writes for the closing edge
    always @(negedge clk) begin
        pend     <= ifc.csr_en && ifc.csr_wr;
        pend_set <= ifc.csr_wr_set;
        pend_clr <= ifc.csr_wr_clr;
        pend_wd  <= ifc.csr_wdata;
        if (ifc.csr_en) begin
            en_cnt    <= en_cnt + 1;
            last_addr <= ifc.csr_addr;
            if (ifc.csr_wr_set) set_cnt <= set_cnt + 1;
            if (ifc.csr_wr)     wr_cnt  <= wr_cnt + 1;
        end
    end

    // responder register applies write/set/clear at the end of the CSR cycle
    always @(posedge clk) begin
        if (pend) mem_val <= pend_set ? (mem_val | pend_wd) : pend_clr ? (mem_val & ~pend_wd) : pend_wd;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [11:0] addr, input logic [63:0] wd, output int lat);
        int n;
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = op;
        ifc.cmd_addr  = addr;
        ifc.cmd_wdata = wd;
        n = 0;
        while (!ifc.cmd_ready && n < 20) begin
            tick;
            n++;
        end
        chk("accept", ifc.cmd_ready, 1);
        tick;
        ifc.cmd_valid = 1'b0;
        lat = 1;
        while (!ifc.rsp_valid && lat < 20) begin
            tick;
            lat++;
        end
    endtask

    task automatic consume;
        ifc.rsp_ready = 1'b1;
        tick;
        ifc.rsp_ready = 1'b0;
    endtask

    initial begin
        int lat, e0, w0, s0, seen;
        int exp_cnt [5] = '{1, 2, 3, 3, 3};
        ifc.cmd_valid = 1'b0;
        ifc.cmd_op    = '0;
        ifc.cmd_addr  = '0;
        ifc.cmd_wdata = '0;
        ifc.rsp_ready = 1'b0;
        tick;
        tick;
        chk("rst_cmd_ready", ifc.cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", ifc.rsp_valid, 0);
        chk("rst_rsp_rdata", ifc.rsp_rdata, 0);
        chk("rst_rsp_error", ifc.rsp_error, 0);
        chk("rst_csr_en", ifc.csr_en, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", ifc.cmd_ready, 1);

        send(2'b01, 12'h3AE, 64'h1234, lat);
        chk("wr_lat", lat, 2 + RB);
        consume;

        e0 = en_cnt;
        w0 = wr_cnt;
        send(2'b00, 12'h3AE, 64'h0, lat);
        chk("rd_lat", lat, 2);
        chk("rd_rdata", ifc.rsp_rdata, 64'h1234);
        chk("rd_error", ifc.rsp_error, 0);
        chk("rd_en_pulses", en_cnt - e0, 1);
        chk("rd_no_wr", wr_cnt - w0, 0);
        chk("rd_addr", last_addr, 12'h3AE);
        chk("rd_busy", busy, 1);
        consume;
        chk("idle_busy", busy, 0);

        send(2'b01, 12'h3A0, 64'hF0, lat);
        consume;
        e0 = en_cnt;
        s0 = set_cnt;
        send(2'b10, 12'h3A0, 64'h0F, lat);
        chk("set_lat", lat, 2 + RB);
        chk("set_rdata", ifc.rsp_rdata, RB ? 64'hFF : 64'hF0);
        chk("set_pulses", set_cnt - s0, 1);
        chk("set_en_pulses", en_cnt - e0, 1 + RB);
        chk("set_addr", last_addr, 12'h3A0);
        consume;

        send(2'b11, 12'h3A0, 64'h0F, lat);
        chk("clr_lat", lat, 2 + RB);
        chk("clr_rdata", ifc.rsp_rdata, RB ? 64'hF0 : 64'hFF);
        consume;

        send(2'b00, 12'h100, 64'h0, lat);
        chk("bp_first_valid", ifc.rsp_valid, 1);
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = 2'b00;
        ifc.cmd_addr  = 12'h200;
        e0 = en_cnt;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", ifc.rsp_valid, 1);
            chk("bp_rsp_rdata", ifc.rsp_rdata, 64'hF0);
            chk("bp_cmd_ready", ifc.cmd_ready, 0);
            chk("bp_no_csr_en", en_cnt - e0, 0);
            tick;
        end
        ifc.rsp_ready = 1'b1;
        tick;
        ifc.rsp_ready = 1'b0;
        chk("bp_pending_ready", ifc.cmd_ready, 1);
        chk("bp_still_no_en", en_cnt - e0, 0);
        tick;
        ifc.cmd_valid = 1'b0;
        chk("bp_second_en", ifc.csr_en, 1);
        chk("bp_second_addr", ifc.csr_addr, 12'h200);
        tick;
        chk("bp_second_rsp", ifc.rsp_valid, 1);
        consume;

        err_inj = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(2'b00, 12'h010, 64'h0, lat);
            chk("err_rsp_error", ifc.rsp_error, 1);
            chk("err_cnt_seq", err_cnt, exp_cnt[i]);
            consume;
        end
        ifc.cmd_valid = 1'b1;
        chk("errclr_ready", ifc.cmd_ready, 1);
        tick;
        ifc.cmd_valid = 1'b0;
        err_clr = 1'b1;
        chk("errclr_en", ifc.csr_en, 1);
        tick;
        err_clr = 1'b0;
        chk("errclr_cnt", err_cnt, 0);
        consume;
        err_inj = 1'b0;

        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = 2'b01;
        ifc.cmd_addr  = 12'h3A0;
        ifc.cmd_wdata = 64'hDEAD;
        chk("mid_rst_ready", ifc.cmd_ready, 1);
        tick;
        ifc.cmd_valid = 1'b0;
        chk("mid_rst_issue", ifc.csr_en, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_en_low", ifc.csr_en, 0);
        chk("mid_rst_busy", busy, 0);
        tick;
        chk("mid_rst_en_after", ifc.csr_en, 0);
        chk("mid_rst_no_rsp", ifc.rsp_valid, 0);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready_after", ifc.cmd_ready, 1);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (ifc.rsp_valid) seen = 1;
        end
        chk("mid_rst_rsp_dropped", seen, 0);
        chk("mid_rst_mem_kept", mem_val, 64'hF0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
